we_reader: RTL and testbench
============================

Name: we_reader

Overview:
Read-side companion to the write-enabled 64-bit register. It snoops the register's write strobe and data, and captures every accepted write into a small first-word-fall-through (FWFT) FIFO. Captured words are delivered in order to a downstream consumer over a valid/ready handshake. Writes that cannot be buffered are counted and flagged, so no update is silently lost.

Parameters:
WIDTH, 64, data word width; must equal the snooped register width.
DEPTH, 4, FIFO entries; power of two, >= 2.
CNT_W, 8, width of the saturating drop counter.

Ports:
clk  input  1  single clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
wn  input  1  write strobe of the snooped register; a write occurs on any cycle with wn=1.
in  input  WIDTH  data written to the snooped register on that cycle.
out_data  output  WIDTH  head-of-FIFO word; 0 when empty.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts out_data this cycle.
level  output  $clog2(DEPTH)+1  current number of stored words, 0..DEPTH.
overflow  output  1  sticky; set when a write is dropped.
ovf_clr  input  1  clears overflow and drop_cnt.
drop_cnt  output  CNT_W  number of dropped writes, saturating.

Behaviour:
- Reset (reset=1 at posedge):
  - rd/wr pointers = 0, level = 0, out_valid = 0, out_data = 0.
  - overflow = 0, drop_cnt = 0.
  - Storage contents are don't-care.
  - reset overrides wn, out_ready and ovf_clr on the same edge.
- Push condition: push = wn && (!full || pop).
  - in is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop condition: pop = out_valid && out_ready. rd_ptr increments modulo DEPTH.
- out_ready while empty is ignored; no underflow, no state change.
- Latency:
  - A word pushed at edge N appears on out_data/out_valid after edge N (FWFT, one cycle).
  - This matches the snooped register's y update timing.
- Simultaneous push and pop:
  - level is unchanged.
  - If full, the push is accepted (the freed slot is reused).
  - If level=1, out_data shows the new word after the edge.
- Drop: wn && full && !pop.
  - in is discarded; the FIFO is unchanged.
  - overflow <= 1.
  - drop_cnt increments, saturating at 2^CNT_W-1 (no wrap).
- ovf_clr:
  - Clears overflow and drop_cnt.
  - If a drop occurs on the same edge: overflow = 1 and drop_cnt = 1 (set wins, count restarts).
- full = (level == DEPTH); empty = (level == 0).
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is tracked as a separate counter; full/empty are decoded from level, not from the pointers.
- out_data is combinational from mem[rd_ptr], masked to 0 when empty.
- No X propagation on outputs after reset.
- Ordering: words leave in exactly the order of accepted wn cycles.
- Back-to-back writes every cycle with out_ready=1 sustain throughput of 1 word/cycle with no drops.

Decomposition:
- Package we_pkg:
  - localparam WORD_W = 64.
  - typedef logic [WORD_W-1:0] word_t.
  - localparam DEFAULT_DEPTH = 4.
  - Shared with the write-enabled register and any future readers.
- Sub-module we_fifo_mem: DEPTH x WIDTH storage, pointers and level counter. Exposes push, pop, head, level, full, empty.
- Top level we_reader: push/pop/drop decode, overflow/drop_cnt logic, out_data masking.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles, release, wn=0 -> out_valid=0, out_data=0, level=0, overflow=0, drop_cnt=0.
2. Single capture: wn=1, in=64'hDEAD_BEEF_0123_4567 for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_data=64'hDEAD_BEEF_0123_4567, level=1. Then out_ready=1 for 1 cycle -> out_valid=0, level=0.
3. Fill and overflow: out_ready=0, 6 consecutive writes in=1..6 -> level=4, overflow=1, drop_cnt=2. Drain with out_ready=1 -> outputs 1,2,3,4 in order, then out_valid=0.
4. Full with simultaneous push/pop: fill with 1..4; one cycle with wn=1, in=5, out_ready=1 -> no drop, level stays 4, drain order 2,3,4,5.
5. Streaming: wn=1 every cycle for 20 cycles with in=cycle index, out_ready=1 -> outputs 0..19 each one cycle after write, level <= 1, drop_cnt=0.
6. Clear race and saturation: with CNT_W=2, force 5 drops -> drop_cnt=3 (saturated). Assert ovf_clr on the same edge as a 6th drop -> overflow=1, drop_cnt=1. Then ovf_clr alone -> overflow=0, drop_cnt=0.

Source files
------------

// File: rtl/we_pkg.sv
// Shared definitions for the write-enabled 64-bit register and its readers.
package we_pkg;

  localparam int WORD_W        = 64;
  localparam int DEFAULT_DEPTH = 4;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/we_fifo_mem.sv
// FWFT storage for we_reader: DEPTH x WIDTH array, wrapping pointers and a level counter.
module we_fifo_mem
  import we_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage carries no reset; the top masks head while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Status comes from the level counter, so equal pointers are never ambiguous.
  always_comb begin
    head  = mem[rd_ptr];
    full  = (level == ($clog2(DEPTH)+1)'(DEPTH));
    empty = (level == '0);
  end

endmodule

// File: rtl/we_reader.sv
// Snoops register writes into an FWFT FIFO and delivers them over valid/ready;
// writes that find the FIFO full are dropped, flagged and counted.
module we_reader
  import we_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wn,
  input  logic [WIDTH-1:0]       in,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic [CNT_W-1:0]       drop_cnt
);

  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] head;

  we_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  always_comb begin
    pop       = !empty && out_ready;
    push      = wn && (!full || pop);
    drop      = wn && full && !pop;
    out_valid = !empty;
    out_data  = empty ? '0 : head;
  end

  // A drop coinciding with ovf_clr wins: the flag stays set and counting restarts at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)
        drop_cnt <= CNT_W'(1);
      else if (drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_we_reader.sv
// Scoreboard bench for we_reader: expected words queued on accepted writes, compared on pop.
module tb_we_reader;

  localparam int W  = 64;
  localparam int D  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wn;
  logic [W-1:0]  in;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    level;
  logic          overflow;
  logic          ovf_clr;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  we_reader #(
    .WIDTH (W),
    .DEPTH (D),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wn        (wn),
    .in        (in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .drop_cnt  (drop_cnt)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] sb [$];
  logic         m_ovf;
  int           m_cnt;

  // One clock of stimulus; model updated alongside, outputs checked before and after the edge.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    logic         p;
    logic         pu;
    logic [W-1:0] exp;
    wn = w; in = d; out_ready = r; ovf_clr = c;
    #1;
    compared++;
    if (out_valid !== (sb.size() != 0)) begin
      mismatched++;
      $display("FAIL out_valid: got %b want %b", out_valid, sb.size() != 0);
    end
    compared++;
    if (level !== 3'(sb.size())) begin
      mismatched++;
      $display("FAIL level: got %0d want %0d", level, sb.size());
    end
    p = (sb.size() != 0) && r;
    if (p) begin
      exp = sb.pop_front();
      compared++;
      if (out_data !== exp) begin
        mismatched++;
        $display("FAIL pop_data: got %h want %h", out_data, exp);
      end
    end else if (sb.size() == 0) begin
      compared++;
      if (out_data !== '0) begin
        mismatched++;
        $display("FAIL empty_data: got %h want 0", out_data);
      end
    end
    pu = w && (sb.size() < D);
    if (pu) sb.push_back(d);
    if (w && !pu) begin
      m_ovf = 1'b1;
      m_cnt = c ? 1 : ((m_cnt == 3) ? 3 : m_cnt + 1);
    end else if (c) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    @(posedge clk); #1;
    compared++;
    if (overflow !== m_ovf) begin
      mismatched++;
      $display("FAIL overflow: got %b want %b", overflow, m_ovf);
    end
    compared++;
    if (drop_cnt !== CW'(m_cnt)) begin
      mismatched++;
      $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, m_cnt);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; wn = 1'b1; in = {$urandom, $urandom}; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; wn = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0);
    compared++;
    if (out_valid !== 1'b0 || out_data !== '0 || level !== 3'd0 ||
        overflow !== 1'b0 || drop_cnt !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got v=%b d=%h l=%0d o=%b c=%0d want all 0",
               out_valid, out_data, level, overflow, drop_cnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    cycle(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
    compared++;
    if (out_valid !== 1'b1 || out_data !== 64'hDEAD_BEEF_0123_4567 || level !== 3'd1) begin
      mismatched++;
      $display("FAIL single_capture: got v=%b d=%h l=%0d want 1 deadbeef01234567 1",
               out_valid, out_data, level);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    compared++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      mismatched++;
      $display("FAIL single_drain: got v=%b l=%0d want 0 0", out_valid, level);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
    compared++;
    if (level !== 3'd4 || overflow !== 1'b1 || drop_cnt !== 2'd2) begin
      mismatched++;
      $display("FAIL fill_overflow: got l=%0d o=%b c=%0d want 4 1 2", level, overflow, drop_cnt);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
    cycle(1'b1, W'(5), 1'b1, 1'b0);
    compared++;
    if (level !== 3'd4 || drop_cnt !== '0 || out_data !== W'(2)) begin
      mismatched++;
      $display("FAIL full_push_pop: got l=%0d c=%0d d=%0d want 4 0 2", level, drop_cnt, out_data);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, W'(i), 1'b1, 1'b0);
      compared++;
      if (level > 3'd1 || out_data !== W'(i)) begin
        mismatched++;
        $display("FAIL stream_%0d: got l=%0d d=%0d want l<=1 d=%0d", i, level, out_data, i);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    compared++;
    if (drop_cnt !== '0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL stream_end: got c=%0d v=%b want 0 0", drop_cnt, out_valid);
    end
  endtask

  task automatic test_clear_race();
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(100 + i), 1'b0, 1'b0);
    compared++;
    if (drop_cnt !== 2'd3 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL saturate: got c=%0d o=%b want 3 1", drop_cnt, overflow);
    end
    cycle(1'b1, W'(200), 1'b0, 1'b1);
    compared++;
    if (drop_cnt !== 2'd1 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL clr_race: got c=%0d o=%b want 1 1", drop_cnt, overflow);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    compared++;
    if (drop_cnt !== 2'd0 || overflow !== 1'b0 || level !== 3'd4) begin
      mismatched++;
      $display("FAIL clr_alone: got c=%0d o=%b l=%0d want 0 0 4", drop_cnt, overflow, level);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_clear_race();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
